// File: rtl/rf_init_sequencer.sv
// Power-up sequencer: holds the RF chip in reset, waits, then streams the command table to the SPI shifter.
// Optional build macro RF_SEQ_EOT_EN: a command whose address field is 16'hFFFF ends the run early.
module rf_init_sequencer #(
   parameter int CMD_DEPTH   = 368,
   parameter int IDX_W       = 9,
   parameter int CMD_W       = 24,
   parameter int RST_CYCLES  = 2000,
   parameter int WAIT_CYCLES = 200
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   output logic [IDX_W-1:0] cmd_addr,
   input  logic [CMD_W-1:0] cmd_rdata,
   output logic             spi_req,
   output logic [CMD_W-1:0] spi_word,
   input  logic             spi_ack,
   output logic             rf_xreset_n,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] cmd_idx,
   output logic [2:0]       dbg_state
);

   localparam int CNT_MAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
   localparam int CNT_W   = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_HOLD_RST = 3'd1,
      S_WAIT_RDY = 3'd2,
      S_FETCH    = 3'd3,
      S_ISSUE    = 3'd4,
      S_WAIT_ACK = 3'd5,
      S_DONE     = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             req_q, req_d;
   logic [CMD_W-1:0] word_q, word_d;
   logic             xr_q, xr_d;
   logic             eot_hit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         req_q   <= 1'b0;
         word_q  <= '0;
         xr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         req_q   <= req_d;
         word_q  <= word_d;
         xr_q    <= xr_d;
      end
   end

`ifdef RF_SEQ_EOT_EN
   assign eot_hit = &cmd_rdata[CMD_W-1:8];
`else
   assign eot_hit = 1'b0;
`endif

   // Handshake: spi_req rises with spi_word and both hold until the cycle spi_ack is
   // sampled high; spi_ack is honoured only while waiting, and req drops the next cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      req_d   = req_q;
      word_d  = word_q;
      xr_d    = xr_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_HOLD_RST;
               cnt_d   = CNT_W'(RST_CYCLES - 1);
               idx_d   = '0;
               xr_d    = 1'b0;
            end
         end
         S_HOLD_RST: begin
            if (cnt_q == '0) begin
               state_d = S_WAIT_RDY;
               cnt_d   = CNT_W'(WAIT_CYCLES - 1);
               xr_d    = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_WAIT_RDY: begin
            if (cnt_q == '0) begin
               state_d = S_FETCH;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_FETCH: begin
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (eot_hit) begin
               state_d = S_DONE;
            end else begin
               state_d = S_WAIT_ACK;
               word_d  = cmd_rdata;
               req_d   = 1'b1;
            end
         end
         S_WAIT_ACK: begin
            if (spi_ack) begin
               req_d = 1'b0;
               if (idx_q == IDX_W'(CMD_DEPTH - 1)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_FETCH;
                  idx_d   = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign cmd_addr    = idx_q;
   assign cmd_idx     = idx_q;
   assign spi_req     = req_q;
   assign spi_word    = word_q;
   assign rf_xreset_n = xr_q;
   assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done        = (state_q == S_DONE);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_rf_init_sequencer.sv
// Randomized bench for rf_init_sequencer: timeline reference model, per-cycle compare, word scoreboard.
module tb_rf_init_sequencer;

  localparam int DEPTH = 3;
  localparam int IW    = 2;
  localparam int W     = 24;
  localparam int RSTC  = 4;
  localparam int WAITC = 3;
`ifdef RF_SEQ_EOT_EN
  localparam bit EOT = 1'b1;
`else
  localparam bit EOT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          spi_ack = 1'b0;
  logic [IW-1:0] cmd_addr, cmd_idx;
  logic [W-1:0]  cmd_rdata = '0;
  logic [W-1:0]  spi_word;
  logic          spi_req, rf_xreset_n, busy, done;
  logic [2:0]    dbg_state;

  rf_init_sequencer #(
    .CMD_DEPTH(DEPTH), .IDX_W(IW), .CMD_W(W), .RST_CYCLES(RSTC), .WAIT_CYCLES(WAITC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cmd_addr(cmd_addr), .cmd_rdata(cmd_rdata),
    .spi_req(spi_req), .spi_word(spi_word), .spi_ack(spi_ack), .rf_xreset_n(rf_xreset_n),
    .busy(busy), .done(done), .cmd_idx(cmd_idx), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // command table, synchronous read
  logic [W-1:0] mem [0:3];
  always @(posedge clk) cmd_rdata <= mem[cmd_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is a timeline -- RSTC cycles in reset, WAITC cycles waiting,
  // then each command's request appears two cycles after the previous ack.
  logic         m_busy = 1'b0, m_done = 1'b0, m_xr = 1'b0, m_req = 1'b0, m_cmds = 1'b0;
  logic [W-1:0] m_word = '0;
  int           m_idx = 0, m_t = 0, m_gap = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_xr <= 1'b0; m_req <= 1'b0; m_cmds <= 1'b0;
      m_word <= '0; m_idx <= 0; m_t <= 0; m_gap <= 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1; m_done <= 1'b0; m_xr <= 1'b0; m_t <= 0; m_idx <= 0; m_cmds <= 1'b0;
      end
    end else if (!m_cmds) begin
      m_t <= m_t + 1;
      if (m_t + 1 == RSTC) m_xr <= 1'b1;
      if (m_t + 1 == RSTC + WAITC) begin
        m_cmds <= 1'b1;
        m_gap  <= 2;
      end
    end else if (m_req) begin
      if (spi_ack) begin
        m_req <= 1'b0;
        if (m_idx == DEPTH - 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
        end else begin
          m_idx <= m_idx + 1;
          m_gap <= 2;
        end
      end
    end else begin
      m_gap <= m_gap - 1;
      if (m_gap == 1) begin
        if (EOT && mem[m_idx][23:8] == 16'hFFFF) begin
          m_busy <= 1'b0; m_done <= 1'b1;
        end else begin
          m_word <= mem[m_idx];
          m_req  <= 1'b1;
        end
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    check("xreset", rf_xreset_n, m_xr);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("spi_req", spi_req, m_req);
    check("spi_word", spi_word, m_word);
    check("cmd_idx", cmd_idx, m_idx);
    check("cmd_addr", cmd_addr, m_idx);
  end

  // monitors: words captured at each request rise, acks accepted
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  logic         prev_req = 1'b0;
  int           ack_seen = 0;

  always @(negedge clk) begin
    if (spi_req && !prev_req) got_q.push_back(spi_word);
    prev_req <= spi_req;
  end

  always @(posedge clk) begin
    if (reset_n && spi_req && spi_ack) ack_seen <= ack_seen + 1;
  end

  // shifter model: ack ack_delay cycles after request, optional stray acks while idle
  int ack_delay = 5;
  bit stray_en = 1'b0;
  bit stray_force = 1'b0;

  initial begin
    int  acnt;
    bit  acked;
    acnt = 0;
    acked = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        spi_ack = 1'b0; acnt = 0; acked = 1'b0;
      end else if (spi_req && !acked) begin
        if (acnt == ack_delay - 1) begin
          spi_ack = 1'b1; acked = 1'b1;
        end else begin
          spi_ack = 1'b0; acnt++;
        end
      end else begin
        spi_ack = !spi_req && (stray_force || (stray_en && $urandom_range(0, 3) == 0));
        stray_force = 1'b0;
        if (!spi_req) begin
          acked = 1'b0; acnt = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", done, 1'b1);
  endtask

  task automatic wait_req_idx(input int idx, input int budget);
    int k;
    k = 0;
    while (!(spi_req && cmd_idx == idx) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("req_timeout", spi_req, 1'b1);
  endtask

  task automatic compare_words(input int base, input string name);
    check({name, "_count"}, got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) check({name, "_word"}, got_q[base + i], exp_q[i]);
    end
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int base, lat, xr_low, xr_high, acks0, k;

    // reset state
    mem[0] = 24'h001234; mem[1] = 24'h0056AB; mem[2] = 24'h00FF01; mem[3] = 24'h0;
    repeat (3) @(negedge clk);
    check("rst_xreset", rf_xreset_n, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_req", spi_req, 1'b0);
    check("rst_word", spi_word, 24'h0);
    check("rst_idx", cmd_idx, 2'd0);
    check("rst_addr", cmd_addr, 2'd0);
    check("rst_state", dbg_state, 3'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // start-to-request latency and xreset timing, ack after 5 cycles
    ack_delay = 5;
    base  = got_q.size();
    acks0 = ack_seen;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; xr_low = 0; xr_high = 0;
    while (!spi_req && lat < 50) begin
      if (rf_xreset_n) xr_high++; else xr_low++;
      @(posedge clk);
      #1 lat++;
    end
    check("start_to_req", lat, 9);
    check("xreset_low_cycles", xr_low, 4);
    check("xreset_high_before_req", xr_high, 5);
    wait_done(200);
    exp_q = '{24'h001234, 24'h0056AB, 24'h00FF01};
    compare_words(base, "seq");
    check("ack_count", ack_seen - acks0, 3);
    check("end_busy", busy, 1'b0);
    check("end_done", done, 1'b1);
    check("end_xreset", rf_xreset_n, 1'b1);

    // stray ack during reset hold and start during an outstanding request
    base = got_q.size();
    pulse_start();
    @(posedge clk);
    #1 stray_force = 1'b1;
    wait_req_idx(1, 200);
    pulse_start();
    wait_done(200);
    compare_words(base, "ignored");

    // reset while waiting on the ack of index 1
    ack_delay = 6;
    pulse_start();
    wait_req_idx(1, 200);
    #2 reset_n = 1'b0;
    #1;
    check("abort_req", spi_req, 1'b0);
    check("abort_xreset", rf_xreset_n, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_idx", cmd_idx, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;
    base = got_q.size();
    pulse_start();
    k = 0;
    while (got_q.size() == base && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("restart_first_seen", got_q.size() > base, 1'b1);
    if (got_q.size() > base) check("restart_first_word", got_q[base], 24'h001234);
    wait_done(200);

    // end-of-table marker
    mem[0] = 24'h001234; mem[1] = 24'hFFFF00; mem[2] = 24'h0056AB;
    ack_delay = 2;
    base = got_q.size();
    pulse_start();
    wait_done(200);
`ifdef RF_SEQ_EOT_EN
    check("eot_count", got_q.size() - base, 1);
    check("eot_idx", cmd_idx, 2'd1);
`else
    check("noeot_count", got_q.size() - base, 3);
    if (got_q.size() > base + 1) check("noeot_marker_word", got_q[base + 1], 24'hFFFF00);
`endif

    // randomized runs
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] = W'($urandom_range(0, 32'hFFFFFF));
        if ($urandom_range(0, 3) == 0) mem[i][23:8] = 16'hFFFF;
      end
      exp_q = {};
      for (int i = 0; i < DEPTH; i++) begin
        if (EOT && mem[i][23:8] == 16'hFFFF) break;
        exp_q.push_back(mem[i]);
      end
      ack_delay = $urandom_range(1, 6);
      stray_en  = ($urandom_range(0, 1) == 1);
      base = got_q.size();
      pulse_start();
      k = 0;
      while (!done && k < 300) begin
        @(negedge clk);
        start = ($urandom_range(0, 9) == 0);
        k++;
      end
      start = 1'b0;
      check("rand_done", done, 1'b1);
      compare_words(base, "rand");
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    stray_en = 1'b0;

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
